// File: rtl/button_debounce_pulse_if.sv
// Button bus between the raw push-button source and the debouncer:
// raw level in, clean level plus press/release strobes out.
interface button_debounce_pulse_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronises a bouncing raw input, accepts a new
// level after STABLE_CYCLES matching samples, and emits press/release strobes.
module button_debounce_pulse #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    button_debounce_pulse_if.slave btn
);
    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchroniser chain; only its last stage is visible to the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn.btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Counter is cleared on every path except a continuing WAIT run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench: expected strobes (kind + edge number) are queued when
// the button is driven and matched as the debouncer emits them.
module tb_button_debounce_pulse;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned STABLE_CYCLES = 16;
    localparam int unsigned LAT           = SYNC_STAGES + STABLE_CYCLES;

    typedef struct {
        logic        is_press;
        int unsigned edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    button_debounce_pulse_if bif ();

    int unsigned cyc         = 0;
    int unsigned checks      = 0;
    int unsigned errors      = 0;
    int unsigned press_total = 0;
    int unsigned e0;
    int unsigned p0;
    logic        prev_level  = 1'b0;
    logic        ds_en       = 1'b0;
    logic [2:0]  ds_cnt;
    exp_t        exp_q[$];

    button_debounce_pulse #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 3-bit counter fed by the press strobe.
    always @(posedge clk or posedge reset) begin
        if (reset)                         ds_cnt <= 3'd0;
        else if (ds_en && bif.btn_press)   ds_cnt <= ds_cnt + 3'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input logic is_press, input int unsigned at);
        exp_t e;
        e.is_press = is_press;
        e.edge_no  = at;
        exp_q.push_back(e);
    endtask

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bif.btn_press && bif.btn_release)
            check_eq("both_strobes", 32'({bif.btn_press, bif.btn_release}), 32'd0);
        if (bif.btn_press || bif.btn_release) begin
            if (bif.btn_press) press_total++;
            check_eq("strobe_level_change", 32'(prev_level != bif.btn_level), 32'd1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_strobe", 32'({bif.btn_press, bif.btn_release}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("strobe_kind", 32'(bif.btn_press), 32'(e.is_press));
                check_eq("strobe_edge", cyc, e.edge_no);
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_no < cyc) begin
            e = exp_q.pop_front();
            check_eq("missing_strobe_edge", cyc, e.edge_no);
        end
        prev_level = bif.btn_level;
    end

    initial begin
        reset      = 1'b1;
        bif.btn_in = 1'b0;
        tick(3);
        check_eq("rst_level", 32'(bif.btn_level), 32'd0);
        check_eq("rst_press", 32'(bif.btn_press), 32'd0);
        check_eq("rst_release", 32'(bif.btn_release), 32'd0);

        // Button already held high when reset releases.
        bif.btn_in = 1'b1;
        tick(2);
        reset = 1'b0;
        e0    = cyc;
        expect_strobe(1'b1, e0 + LAT);
        tick(LAT - 1);
        check_eq("por_level_pre", 32'(bif.btn_level), 32'd0);
        tick(1);
        check_eq("por_level_post", 32'(bif.btn_level), 32'd1);

        // Asynchronous reset between edges while level is high.
        tick(5);
        #3 reset = 1'b1;
        #1;
        check_eq("async_rst_level", 32'(bif.btn_level), 32'd0);
        check_eq("async_rst_press", 32'(bif.btn_press), 32'd0);
        check_eq("async_rst_release", 32'(bif.btn_release), 32'd0);
        tick(2);
        reset = 1'b0;
        e0    = cyc;
        expect_strobe(1'b1, e0 + LAT);
        tick(LAT - 1);
        check_eq("rerst_level_pre", 32'(bif.btn_level), 32'd0);
        tick(1);
        check_eq("rerst_level_post", 32'(bif.btn_level), 32'd1);

        // Release from stable high.
        tick(3);
        bif.btn_in = 1'b0;
        e0         = cyc;
        expect_strobe(1'b0, e0 + LAT);
        tick(LAT - 1);
        check_eq("release_level_pre", 32'(bif.btn_level), 32'd1);
        tick(1);
        check_eq("release_level_post", 32'(bif.btn_level), 32'd0);

        // Clean press held for 100 cycles, then released.
        tick(5);
        bif.btn_in = 1'b1;
        e0         = cyc;
        expect_strobe(1'b1, e0 + LAT);
        tick(LAT - 1);
        check_eq("press_level_pre", 32'(bif.btn_level), 32'd0);
        tick(1);
        check_eq("press_level_post", 32'(bif.btn_level), 32'd1);
        tick(100);
        check_eq("press_held_level", 32'(bif.btn_level), 32'd1);
        bif.btn_in = 1'b0;
        expect_strobe(1'b0, cyc + LAT);
        tick(25);
        check_eq("press_released_level", 32'(bif.btn_level), 32'd0);

        // Bounce: toggle every 5 cycles for 60 cycles, ending low.
        for (int i = 0; i < 12; i++) begin
            bif.btn_in = ~bif.btn_in;
            tick(5);
        end
        tick(25);
        check_eq("bounce_level", 32'(bif.btn_level), 32'd0);

        // Near miss: 15 cycles high is one sample short.
        bif.btn_in = 1'b1;
        tick(STABLE_CYCLES - 1);
        bif.btn_in = 1'b0;
        tick(30);
        check_eq("nearmiss15_level", 32'(bif.btn_level), 32'd0);

        // Exactly 16 cycles high is accepted.
        bif.btn_in = 1'b1;
        expect_strobe(1'b1, cyc + LAT);
        tick(STABLE_CYCLES);
        bif.btn_in = 1'b0;
        expect_strobe(1'b0, cyc + LAT);
        tick(LAT - 1);
        check_eq("exact16_level_pre", 32'(bif.btn_level), 32'd1);
        tick(1);
        check_eq("exact16_level_post", 32'(bif.btn_level), 32'd0);
        tick(10);

        // Downstream integration: nine clean presses.
        ds_en = 1'b1;
        p0    = press_total;
        for (int i = 0; i < 9; i++) begin
            bif.btn_in = 1'b1;
            expect_strobe(1'b1, cyc + LAT);
            tick(25);
            bif.btn_in = 1'b0;
            expect_strobe(1'b0, cyc + LAT);
            tick(25);
        end
        check_eq("ds_counter", 32'(ds_cnt), 32'd1);
        check_eq("ds_press_count", press_total - p0, 32'd9);

        tick(5);
        check_eq("pending_strobes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
